// File: rtl/stu_operand_packer_pkg.sv
// Shared types for the store-operand packer.
// Default geometry mirrors the vector unit: two 64-bit ELEN slots per packed word.
package stu_operand_packer_pkg;

  localparam int unsigned Nr_SIMD = 2;
  localparam int unsigned ELEN    = 64;

  typedef logic [ELEN-1:0]         elen_t;
  typedef logic [Nr_SIMD*ELEN-1:0] elen_simd_t;
  typedef logic [Nr_SIMD-1:0]      stu_pack_slot_mask_t;

  // Packed word as handed to the store unit
  typedef struct packed {
    elen_simd_t          data;
    stu_pack_slot_mask_t mask;
    logic                last;
  } stu_pack_word_t;

endpackage

// File: rtl/stu_pack_acc.sv
// Slot counter plus data/mask accumulator for the store-operand packer.
// A closing beat either clears the accumulator (group moved on) or, when
// 'keep' is high, freezes the completed group in place until 'flush'.
// Under STU_PACK_DBUF_EN the closing group is also exposed combinationally
// so the top can move it into its output register on the closing cycle.
module stu_pack_acc
  import stu_operand_packer_pkg::*;
#(
  parameter int unsigned NrSimd = Nr_SIMD,
  parameter int unsigned ElenW  = ELEN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     beat_vld,
  input  logic [ElenW-1:0]         beat_data,
  input  logic                     beat_last,
  input  logic                     keep,
  input  logic                     flush,
  output logic [NrSimd*ElenW-1:0]  acc_data,
  output logic [NrSimd-1:0]        acc_mask,
  output logic                     acc_last,
  output logic                     acc_closed,
`ifdef STU_PACK_DBUF_EN
  output logic                     close,
  output logic [NrSimd*ElenW-1:0]  merged_data,
  output logic [NrSimd-1:0]        merged_mask,
`endif
  output logic                     cnt_nz
);

  localparam int unsigned CntW = $clog2(NrSimd);
  localparam logic [CntW-1:0] LastSlot = CntW'(NrSimd - 1);

  logic [CntW-1:0]         cnt_p0;
  logic [NrSimd*ElenW-1:0] data_p0;
  logic [NrSimd-1:0]       mask_p0;
  logic                    last_p0;
  logic                    closed_p0;

  logic [NrSimd*ElenW-1:0] nxt_data;
  logic [NrSimd-1:0]       nxt_mask;
  logic                    grp_close;

  // Current group with the incoming beat dropped into slot cnt
  always_comb begin
    nxt_data = data_p0;
    nxt_mask = mask_p0;
    nxt_data[ElenW*int'(cnt_p0) +: ElenW] = beat_data;
    nxt_mask[cnt_p0] = 1'b1;
  end

  assign grp_close = beat_vld && ((cnt_p0 == LastSlot) || beat_last);

  // ---- stage p0: accumulator ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_p0    <= '0;
      data_p0   <= '0;
      mask_p0   <= '0;
      last_p0   <= 1'b0;
      closed_p0 <= 1'b0;
    end else if (flush) begin
      data_p0   <= '0;
      mask_p0   <= '0;
      last_p0   <= 1'b0;
      closed_p0 <= 1'b0;
    end else if (beat_vld) begin
      if (grp_close) begin
        cnt_p0 <= '0;
        if (keep) begin
          data_p0   <= nxt_data;
          mask_p0   <= nxt_mask;
          last_p0   <= beat_last;
          closed_p0 <= 1'b1;
        end else begin
          data_p0 <= '0;
          mask_p0 <= '0;
          last_p0 <= 1'b0;
        end
      end else begin
        cnt_p0  <= cnt_p0 + CntW'(1);
        data_p0 <= nxt_data;
        mask_p0 <= nxt_mask;
      end
    end
  end

  assign acc_data   = data_p0;
  assign acc_mask   = mask_p0;
  assign acc_last   = last_p0;
  assign acc_closed = closed_p0;
  assign cnt_nz     = (cnt_p0 != '0);

`ifdef STU_PACK_DBUF_EN
  assign close       = grp_close;
  assign merged_data = nxt_data;
  assign merged_mask = nxt_mask;
`endif

endmodule

// File: rtl/stu_operand_packer.sv
// Store-operand packer: gathers NrSimd ELEN beats into one packed word for the
// vector store unit, zero-padding a short final group and flagging live slots.
// Optional macro STU_PACK_DBUF_EN adds an output register behind the
// accumulator so beats keep flowing while a packed word waits.
module stu_operand_packer
  import stu_operand_packer_pkg::*;
#(
  parameter int unsigned NrSimd = Nr_SIMD,
  parameter int unsigned ElenW  = ELEN
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ElenW-1:0]        in_operand_i,
  input  logic                    in_valid_i,
  input  logic                    in_last_i,
  output logic                    in_ready_o,
  output logic [NrSimd*ElenW-1:0] out_operand_o,
  output logic [NrSimd-1:0]       out_slot_mask_o,
  output logic                    out_last_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic                    busy_o
);

  logic                    beat_vld;
  logic                    keep;
  logic                    flush;
  logic [NrSimd*ElenW-1:0] acc_data;
  logic [NrSimd-1:0]       acc_mask;
  logic                    acc_last;
  logic                    acc_closed;
  logic                    cnt_nz;

  assign beat_vld = in_valid_i && in_ready_o;

`ifdef STU_PACK_DBUF_EN
  logic                    close;
  logic [NrSimd*ElenW-1:0] merged_data;
  logic [NrSimd-1:0]       merged_mask;
  logic                    move_ok;
  logic [NrSimd*ElenW-1:0] data_p1;
  logic [NrSimd-1:0]       mask_p1;
  logic                    last_p1;
  logic                    vld_p1;
`endif

  stu_pack_acc #(
    .NrSimd (NrSimd),
    .ElenW  (ElenW)
  ) u_acc (
    .clk         (clk_i),
    .rst_n       (rst_ni),
    .beat_vld    (beat_vld),
    .beat_data   (in_operand_i),
    .beat_last   (in_last_i),
    .keep        (keep),
    .flush       (flush),
    .acc_data    (acc_data),
    .acc_mask    (acc_mask),
    .acc_last    (acc_last),
    .acc_closed  (acc_closed),
`ifdef STU_PACK_DBUF_EN
    .close       (close),
    .merged_data (merged_data),
    .merged_mask (merged_mask),
`endif
    .cnt_nz      (cnt_nz)
  );

`ifdef STU_PACK_DBUF_EN
  // Output slot is free when empty or draining this cycle
  assign move_ok = !vld_p1 || out_ready_i;
  assign keep    = !move_ok;
  assign flush   = acc_closed && move_ok;

  // ---- stage p1: output register fed by held group or closing group ----
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_p1 <= '0;
      mask_p1 <= '0;
      last_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (acc_closed && move_ok) begin
      data_p1 <= acc_data;
      mask_p1 <= acc_mask;
      last_p1 <= acc_last;
      vld_p1  <= 1'b1;
    end else if (close && move_ok) begin
      data_p1 <= merged_data;
      mask_p1 <= merged_mask;
      last_p1 <= in_last_i;
      vld_p1  <= 1'b1;
    end else if (vld_p1 && out_ready_i) begin
      data_p1 <= '0;
      mask_p1 <= '0;
      last_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end
  end

  assign out_operand_o   = data_p1;
  assign out_slot_mask_o = mask_p1;
  assign out_last_o      = last_p1;
  assign out_valid_o     = vld_p1;
  assign in_ready_o      = !acc_closed;
  assign busy_o          = cnt_nz || vld_p1 || acc_closed;
`else
  // Accumulator doubles as the output register: a closed group is the valid word
  assign keep            = 1'b1;
  assign flush           = acc_closed && out_ready_i;
  assign out_operand_o   = acc_data;
  assign out_slot_mask_o = acc_mask;
  assign out_last_o      = acc_last;
  assign out_valid_o     = acc_closed;
  assign in_ready_o      = !acc_closed;
  assign busy_o          = cnt_nz || acc_closed;
`endif

endmodule

// File: doc/stu_operand_packer.md
Name: stu_operand_packer

Overview:
- Upstream feeder of the vector store unit. Collects ELEN-wide store operand beats from the lane side and packs NrSimd of them into one elen_simd_t word.
- The packed word drives the VLSU stu_operand_i / stu_operand_valid_i / stu_operand_ready_o handshake.
- Handles a short final group (instruction end) by zero-padding and flagging which slots are populated.

Parameters:
- NrSimd, 2 (ara_pkg::Nr_SIMD), number of ELEN slots per packed word; must be >= 2.
- ElenW, 64 (ara_pkg::ELEN), width of one operand slot in bits.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- in_operand_i  in  ElenW  lane-side operand beat
- in_valid_i  in  1  beat valid
- in_last_i  in  1  beat is the last of the current store instruction
- in_ready_o  out  1  packer accepts beat
- out_operand_o  out  NrSimd*ElenW  packed word; slot i at bits [ElenW*(i+1)-1 : ElenW*i]
- out_slot_mask_o  out  NrSimd  bit i set = slot i holds real data
- out_last_o  out  1  packed word closes the instruction
- out_valid_o  out  1  packed word valid (to VLSU stu_operand_valid_i)
- out_ready_i  in  1  VLSU stu_operand_ready_o
- busy_o  out  1  partial group held or output valid

Behaviour:
- Interface: one clock, clk_i. Reset is synchronous and active-low on rst_ni.
- Reset (rst_ni=0 at a clk_i edge): slot counter cnt=0, out_valid_o=0, out_operand_o=0, out_slot_mask_o=0, out_last_o=0, busy_o=0. Reset mid-group discards the partial group; no output is emitted.
- Accept: a beat transfers when in_valid_i && in_ready_o.
  - It is written into slot cnt, and mask bit cnt is set.
  - cnt is $clog2(NrSimd) bits wide.
- Group close: on an accepted beat with cnt==NrSimd-1 or in_last_i=1:
  - the group is complete and cnt returns to 0;
  - out_last_o = in_last_i of that beat.
- Otherwise cnt increments by 1.
- Unfilled slots of a closed group are 0, and their mask bits are 0.
- Latency: out_valid_o rises on the cycle after the closing beat is accepted. No combinational path from in_* to out_*.
- Output handshake:
  - out_valid_o, once high, holds with out_operand_o, out_slot_mask_o and out_last_o stable until out_valid_o && out_ready_i.
  - On that cycle the output registers clear: mask=0, data=0, last=0.
- Backpressure (feature off): accumulation shares the output register. in_ready_o = !out_valid_o. No beat is accepted while a packed word waits.
- in_last_i with cnt==NrSimd-1 is a normal full group with out_last_o=1.
- A first beat with in_last_i=1 yields out_slot_mask_o = 1 in the LSB only.
- busy_o = (cnt!=0) || out_valid_o.
- The packer never emits an empty group (mask=0).

Optional Feature:
- Macro: STU_PACK_DBUF_EN.
- Defined:
  - A separate accumulator register plus the output register (double buffer).
  - The accumulator keeps filling while the output waits.
  - in_ready_o = !acc_closed, where acc_closed means a completed group is waiting to move to the output.
  - The accumulator moves to the output when !out_valid_o || out_ready_i.
  - That move may happen on the same cycle the closing beat is accepted, giving the same 1-cycle latency.
  - Full-rate streaming: one packed word per NrSimd cycles with out_ready_i tied high and no bubbles at group boundaries.
  - busy_o also covers acc_closed.
- Undefined: single register, behaviour as above.

Decomposition:
- ara_pkg: Nr_SIMD, ELEN, elen_t and elen_simd_t (existing).
- Add to ara_pkg:
  - stu_pack_slot_mask_t = logic [Nr_SIMD-1:0];
  - the packed output struct {elen_simd_t data; stu_pack_slot_mask_t mask; logic last}.
- Natural sub-module: stu_pack_acc (slot counter plus data/mask accumulator with a close pulse). Instantiated once; under STU_PACK_DBUF_EN it feeds the separate output register.

Test Plan:
- Reset sequence (shared setup, not a counted scenario): hold rst_ni=0 for 2 cycles mid-stream with a partial group held → all outputs 0, busy_o=0, and no stale word appears after release.
- Full group: NrSimd=2, beats 0x11 then 0x22, out_ready_i=1 → one cycle after the 2nd beat: out_operand_o=0x0000000000000022_0000000000000011, mask=2'b11, last=0.
- Short last: beat 0xAB with in_last_i=1 at cnt=0 → out_operand_o upper slot 0, lower 0xAB, mask=2'b01, last=1; the next group starts at slot 0.
- Backpressure, feature off: group closed, out_ready_i=0 for 5 cycles → in_ready_o=0 for those cycles and the output stays stable. The word drains on the cycle out_ready_i=1 and in_ready_o=1 the following cycle.
- Streaming, STU_PACK_DBUF_EN defined: 8 back-to-back beats, out_ready_i=1 → 4 packed words, out_valid_o high on 4 cycles spaced every 2 cycles, in_ready_o never low.
- DBUF stall: out_ready_i=0 with accumulator full → in_ready_o=0 after 2×NrSimd beats accepted; release → both words emitted in order with no data loss.
